// File: rtl/mnist_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its surroundings: the pixel
// source (valid/ready beats), the classifier (start/done) and the result
// consumer (valid/ack), plus status outputs.
interface mnist_frame_sequencer_if #(
    parameter int ROWS  = 14,
    parameter int COLS  = 14,
    parameter int BUS_W = 7
);
    logic                   start;
    logic                   abort;
    logic                   in_valid;
    logic [BUS_W-1:0]       data_in;
    logic                   in_ready;
    logic [ROWS*COLS-1:0]   image_data;
    logic                   image_valid;
    logic                   nn_start;
    logic                   nn_done;
    logic [3:0]             nn_class;
    logic [3:0]             class_out;
    logic                   class_valid;
    logic                   class_ack;
    logic                   error;
    logic                   busy;

    // Environment side: pixel source, classifier and result consumer.
    modport master (
        output start, abort, in_valid, data_in, nn_done, nn_class, class_ack,
        input  in_ready, image_data, image_valid, nn_start, class_out,
               class_valid, error, busy
    );

    // Sequencer side.
    modport slave (
        input  start, abort, in_valid, data_in, nn_done, nn_class, class_ack,
        output in_ready, image_data, image_valid, nn_start, class_out,
               class_valid, error, busy
    );
endinterface

// File: rtl/mnist_frame_sequencer.sv
// Frame sequencer for a 14x14 binary MNIST classifier: loads one frame as
// BUS_W-pixel beats (first beat in the MSBs), pulses the classifier start,
// waits for its result under a timeout watchdog and holds the result until
// the consumer acknowledges it. abort cancels any frame in progress.
module mnist_frame_sequencer #(
    parameter int ROWS    = 14,
    parameter int COLS    = 14,
    parameter int BUS_W   = 7,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mnist_frame_sequencer_if.slave  bus
);
    localparam int N      = ROWS * COLS;
    localparam int BEATS  = N / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [N-1:0]        image_data_q;
    logic                in_ready_q;
    logic                image_valid_q;
    logic                nn_start_q;
    logic [3:0]          class_out_q;
    logic                class_valid_q;
    logic                error_q;

    logic beat_accept;
    logic last_beat;

    assign beat_accept = (state_q == S_LOAD) && in_ready_q && bus.in_valid;
    assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));

    // Sequencer FSM with registered handshake outputs; abort overrides every
    // other event in a non-idle state, but leaves error and class_out alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            tmo_q         <= '0;
            image_data_q  <= '0;
            in_ready_q    <= 1'b0;
            image_valid_q <= 1'b0;
            nn_start_q    <= 1'b0;
            class_out_q   <= 4'h0;
            class_valid_q <= 1'b0;
            error_q       <= 1'b0;
        end else if (bus.abort && (state_q != S_IDLE)) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            tmo_q         <= '0;
            in_ready_q    <= 1'b0;
            image_valid_q <= 1'b0;
            nn_start_q    <= 1'b0;
            class_valid_q <= 1'b0;
        end else begin
            nn_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q       <= S_LOAD;
                        in_ready_q    <= 1'b1;
                        beat_q        <= '0;
                        image_valid_q <= 1'b0;
                        error_q       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (beat_accept) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (beat_q == BEAT_W'(b)) begin
                                image_data_q[N-1-BUS_W*b -: BUS_W] <= bus.data_in;
                            end
                        end
                        if (last_beat) begin
                            state_q       <= S_START;
                            in_ready_q    <= 1'b0;
                            image_valid_q <= 1'b1;
                            nn_start_q    <= 1'b1;
                            beat_q        <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                    tmo_q   <= '0;
                end
                S_WAIT: begin
                    if (bus.nn_done) begin
                        class_out_q   <= bus.nn_class;
                        class_valid_q <= 1'b1;
                        state_q       <= S_DONE;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        class_out_q   <= 4'hF;
                        error_q       <= 1'b1;
                        class_valid_q <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.class_ack) begin
                        class_valid_q <= 1'b0;
                        if (bus.start) begin
                            state_q       <= S_LOAD;
                            in_ready_q    <= 1'b1;
                            beat_q        <= '0;
                            image_valid_q <= 1'b0;
                            error_q       <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.image_data  = image_data_q;
    assign bus.image_valid = image_valid_q;
    assign bus.nn_start    = nn_start_q;
    assign bus.class_out   = class_out_q;
    assign bus.class_valid = class_valid_q;
    assign bus.error       = error_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_mnist_frame_sequencer.sv
// Directed bench for mnist_frame_sequencer (TIMEOUT=16): nominal frame,
// stalled load, timeout and late done, back-to-back frame, abort with
// spurious nn_done, and asynchronous reset during WAIT.
module tb_mnist_frame_sequencer;
    localparam int ROWS = 14;
    localparam int COLS = 14;
    localparam int BUS_W = 7;
    localparam int N = ROWS * COLS;
    localparam int BEATS = N / BUS_W;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [BUS_W-1:0] beats [BEATS];

    mnist_frame_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .BUS_W(BUS_W)) bus ();

    mnist_frame_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .BUS_W(BUS_W), .TIMEOUT(16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame built pixel by pixel: pixel (r,c) at bit N-1-(COLS*r+c).
    // mode 0: columns 0-6 set in every row; mode 1: as mode 0 but rows 0-4
    // clear; mode 2: beat b carries value b, leftmost pixel = MSB of the beat.
    function automatic logic [N-1:0] exp_img(input int mode);
        logic [N-1:0] img;
        int b;
        logic [6:0] v;
        img = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                b = 2 * r + c / 7;
                v = 7'(b);
                case (mode)
                    0:       img[N-1-(COLS*r+c)] = (c < 7);
                    1:       img[N-1-(COLS*r+c)] = (c < 7) && (r >= 5);
                    default: img[N-1-(COLS*r+c)] = v[6 - (c % 7)];
                endcase
            end
        end
        return img;
    endfunction

    task automatic set_beats(input int mode);
        for (int b = 0; b < BEATS; b++) begin
            if (mode == 0) beats[b] = (b % 2 == 0) ? 7'h7F : 7'h00;
            else           beats[b] = 7'(b);
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Offer beats until BEATS acceptances; reports acceptances and any
    // nn_start seen before the final acceptance.
    task automatic load_frame(input bit stall, output int acc, output int early);
        int guard;
        logic a;
        acc = 0;
        early = 0;
        guard = 0;
        while (acc < BEATS && guard < 500) begin
            bus.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.data_in  = beats[acc];
            a = bus.in_valid && bus.in_ready;
            tick();
            if (a) acc++;
            if (acc < BEATS && bus.nn_start) early++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
    endtask

    // Starting on the nn_start cycle: counts cycles until class_valid,
    // pulsing nn_done on relative cycle done_at (negative = never).
    task automatic wait_class(input int done_at, input logic [3:0] cls,
                              output int n, output int starts);
        n = 0;
        starts = 0;
        while (!bus.class_valid && n < 64) begin
            bus.nn_done  = (n == done_at);
            bus.nn_class = cls;
            tick();
            n++;
            if (bus.nn_start) starts++;
        end
        bus.nn_done  = 1'b0;
        bus.nn_class = 4'h0;
    endtask

    task automatic ack();
        bus.class_ack = 1'b1;
        tick();
        bus.class_ack = 1'b0;
    endtask

    initial begin
        int acc, early, n, st;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.nn_done   = 1'b0;
        bus.nn_class  = 4'h0;
        bus.class_ack = 1'b0;
        #12;
        chk("rst_flags", {bus.in_ready, bus.image_valid, bus.nn_start,
                          bus.class_valid, bus.error, bus.busy}, 6'b0);
        chk("rst_image", bus.image_data, '0);
        chk("rst_class", bus.class_out, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("idle_in_ready", bus.in_ready, 1'b0);

        // Nominal frame
        set_beats(0);
        do_start();
        chk("nom_in_ready", bus.in_ready, 1'b1);
        chk("nom_busy", bus.busy, 1'b1);
        load_frame(1'b0, acc, early);
        chk("nom_acc", acc, BEATS);
        chk("nom_nn_start", bus.nn_start, 1'b1);
        chk("nom_img_valid", bus.image_valid, 1'b1);
        chk("nom_in_ready_lo", bus.in_ready, 1'b0);
        chk("nom_image", bus.image_data, exp_img(0));
        chk("nom_row0", bus.image_data[195:182], 14'h3F80);
        wait_class(3, 4'd7, n, st);
        chk("nom_latency", n, 4);
        chk("nom_extra_start", st, 0);
        chk("nom_class", bus.class_out, 4'd7);
        chk("nom_error", bus.error, 1'b0);
        tick();
        tick();
        chk("nom_hold", {bus.class_valid, bus.class_out}, {1'b1, 4'd7});
        ack();
        chk("nom_ack_cv", bus.class_valid, 1'b0);
        chk("nom_ack_busy", bus.busy, 1'b0);
        chk("nom_img_kept", bus.image_valid, 1'b1);

        // Spurious nn_done in IDLE
        bus.nn_done = 1'b1;
        tick();
        bus.nn_done = 1'b0;
        tick();
        chk("idle_done_cv", {bus.class_valid, bus.busy, bus.class_out}, {2'b00, 4'd7});

        // Stalled load
        do_start();
        load_frame(1'b1, acc, early);
        chk("stall_acc", acc, BEATS);
        chk("stall_early", early, 0);
        chk("stall_nn_start", bus.nn_start, 1'b1);
        chk("stall_image", bus.image_data, exp_img(0));
        wait_class(2, 4'd3, n, st);
        chk("stall_latency", n, 3);
        chk("stall_class", bus.class_out, 4'd3);
        ack();

        // Timeout with no nn_done
        do_start();
        load_frame(1'b0, acc, early);
        wait_class(-1, 4'd0, n, st);
        chk("tmo_latency", n, 17);
        chk("tmo_class", bus.class_out, 4'hF);
        chk("tmo_error", bus.error, 1'b1);

        // Back-to-back: ack and start together in DONE
        bus.class_ack = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.class_ack = 1'b0;
        bus.start     = 1'b0;
        chk("b2b_cv", bus.class_valid, 1'b0);
        chk("b2b_in_ready", bus.in_ready, 1'b1);
        chk("b2b_img_valid", bus.image_valid, 1'b0);
        chk("b2b_error", bus.error, 1'b0);

        // nn_done on the last WAIT cycle still counts
        load_frame(1'b0, acc, early);
        chk("late_acc", acc, BEATS);
        wait_class(16, 4'd9, n, st);
        chk("late_latency", n, 17);
        chk("late_class", bus.class_out, 4'd9);
        chk("late_error", bus.error, 1'b0);
        ack();

        // Abort on beat 10, with a spurious nn_done during LOAD
        do_start();
        for (int b = 0; b < 10; b++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = 7'h00;
            bus.nn_done  = (b == 3);
            tick();
        end
        bus.nn_done = 1'b0;
        chk("load_done_cv", {bus.class_valid, bus.in_ready}, 2'b01);
        bus.data_in = 7'h00;
        bus.abort   = 1'b1;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_in_ready", bus.in_ready, 1'b0);
        chk("abort_class_hold", bus.class_out, 4'd9);
        chk("abort_image", bus.image_data, exp_img(1));
        tick();
        chk("abort_idle", bus.busy, 1'b0);

        // New start reloads from beat 0
        set_beats(2);
        do_start();
        load_frame(1'b0, acc, early);
        chk("reload_image", bus.image_data, exp_img(2));
        wait_class(1, 4'd5, n, st);
        chk("reload_latency", n, 2);
        chk("reload_class", bus.class_out, 4'd5);
        ack();

        // Asynchronous reset in the middle of WAIT
        do_start();
        load_frame(1'b0, acc, early);
        tick();
        tick();
        tick();
        chk("wait_busy", bus.busy, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_flags", {bus.in_ready, bus.image_valid, bus.nn_start,
                           bus.class_valid, bus.error, bus.busy}, 6'b0);
        chk("arst_image", bus.image_data, '0);
        chk("arst_class", bus.class_out, 4'h0);
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_idle", {bus.busy, bus.in_ready, bus.class_valid}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
